// File: rtl/rv_pkg.sv
// Shared definitions for the register-file write path.
//   XLEN        : default datapath width
//   REG_ADDR_W  : architectural register index width
//   NUM_REGS    : number of architectural registers
//   llu_result_t: one buffered long-latency-unit result {rd, data}
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } llu_result_t;

  localparam int LLU_RES_W = $bits(llu_result_t);

  // One-hot decode of a register index into a scoreboard-sized mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m     = {NUM_REGS{1'b0}};
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/llu_result_fifo.sv
// Synchronous FIFO holding long-latency-unit results until a free write slot.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i        : enqueue push_data_i (ignored while full)
//   push_data_i   : entry to enqueue
//   pop_i         : dequeue head (ignored while empty)
//   full_o/empty_o: occupancy flags, derived from registered state only
//   head_o        : oldest entry (zero when empty)
module llu_result_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = LLU_RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == {CW{1'b0}});
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Next-state pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Head is forced to zero when empty so no stale data is ever presented.
  always_comb begin
    head_o = {WIDTH{1'b0}};
    if (!empty_o) begin
      head_o = mem_q[rd_ptr_q];
    end else begin
      head_o = {WIDTH{1'b0}};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// writeback stage and buffered long-latency-unit (LLU) results.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   RegWriteW, RdW, ResultW       : writeback-stage write request (highest priority)
//   LlIssueValid, LlIssueRd       : LLU op issue, marks destination pending
//   LlValid, LlRd, LlData, LlReady: LLU result handshake
//   RegWriteRF, RdRF, WriteDataRF : register-file write port
//   PendingMask                   : outstanding LLU destinations (for hazard stalls)
//   StallReq                      : ask the front end for a bubble when LLU results starve
module rf_write_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN         = rv_pkg::XLEN,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]       ResultW,
  input  logic                  LlIssueValid,
  input  logic [REG_ADDR_W-1:0] LlIssueRd,
  input  logic                  LlValid,
  input  logic [REG_ADDR_W-1:0] LlRd,
  input  logic [XLEN-1:0]       LlData,
  output logic                  LlReady,
  output logic                  RegWriteRF,
  output logic [REG_ADDR_W-1:0] RdRF,
  output logic [XLEN-1:0]       WriteDataRF,
  output logic [NUM_REGS-1:0]   PendingMask,
  output logic                  StallReq
);

  localparam int EW = REG_ADDR_W + XLEN;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic                  slot_busy_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [EW-1:0]         push_ent_s;
  logic [EW-1:0]         head_ent_s;
  logic [REG_ADDR_W-1:0] head_rd_s;
  logic [XLEN-1:0]       head_data_s;

  logic [NUM_REGS-1:0]   pend_q, pend_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  stall_q;

  // RdW = x0 is a write that the register file discards, so it leaves the slot free.
  assign slot_busy_s = RegWriteW && (RdW != {REG_ADDR_W{1'b0}});

  // Drain only into a slot the pipeline does not need.
  assign pop_s = !slot_busy_s && !fifo_empty_s;

  // LlReady depends on FIFO state only; results to x0 are handshaken but not stored.
  assign LlReady    = !fifo_full_s;
  assign push_s     = LlValid && !fifo_full_s && (LlRd != {REG_ADDR_W{1'b0}});
  assign push_ent_s = {LlRd, LlData};

  assign head_rd_s   = head_ent_s[EW-1:XLEN];
  assign head_data_s = head_ent_s[XLEN-1:0];

  llu_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .push_data_i (push_ent_s),
    .pop_i       (pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .head_o      (head_ent_s)
  );

  // Write-port mux: pipeline first, then FIFO head, else idle with zeroed address/data.
  always_comb begin
    RegWriteRF  = 1'b0;
    RdRF        = {REG_ADDR_W{1'b0}};
    WriteDataRF = {XLEN{1'b0}};
    if (slot_busy_s) begin
      RegWriteRF  = 1'b1;
      RdRF        = RdW;
      WriteDataRF = ResultW;
    end else if (!fifo_empty_s) begin
      RegWriteRF  = 1'b1;
      RdRF        = head_rd_s;
      WriteDataRF = head_data_s;
    end else begin
      RegWriteRF  = 1'b0;
      RdRF        = {REG_ADDR_W{1'b0}};
      WriteDataRF = {XLEN{1'b0}};
    end
  end

  // Scoreboard next state: clear on drain, then set on issue so a same-bit set wins.
  always_comb begin
    pend_d = pend_q;
    if (pop_s) begin
      pend_d = pend_d & ~reg_onehot(head_rd_s);
    end else begin
      pend_d = pend_d;
    end
    if (LlIssueValid && (LlIssueRd != {REG_ADDR_W{1'b0}})) begin
      pend_d = pend_d | reg_onehot(LlIssueRd);
    end else begin
      pend_d = pend_d;
    end
    pend_d[0] = 1'b0;
  end

  // Starvation counter: counts blocked cycles with data waiting, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty_s || pop_s) begin
      starve_d = {SW{1'b0}};
    end else if (slot_busy_s && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers; StallReq is registered from the counter's next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= {NUM_REGS{1'b0}};
      starve_q <= {SW{1'b0}};
      stall_q  <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      starve_q <= starve_d;
      stall_q  <= (starve_d == STARVE_MAX);
    end
  end

  assign PendingMask = pend_q;
  assign StallReq    = stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        LlIssueValid;
  logic [4:0]  LlIssueRd;
  logic        LlValid;
  logic [4:0]  LlRd;
  logic [31:0] LlData;
  logic        LlReady;
  logic        RegWriteRF;
  logic [4:0]  RdRF;
  logic [31:0] WriteDataRF;
  logic [31:0] PendingMask;
  logic        StallReq;

  int errors;
  int checks;

  rf_write_arbiter #(
    .XLEN         (32),
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RegWriteW    (RegWriteW),
    .RdW          (RdW),
    .ResultW      (ResultW),
    .LlIssueValid (LlIssueValid),
    .LlIssueRd    (LlIssueRd),
    .LlValid      (LlValid),
    .LlRd         (LlRd),
    .LlData       (LlData),
    .LlReady      (LlReady),
    .RegWriteRF   (RegWriteRF),
    .RdRF         (RdRF),
    .WriteDataRF  (WriteDataRF),
    .PendingMask  (PendingMask),
    .StallReq     (StallReq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    RegWriteW    = 1'b0;
    RdW          = 5'd0;
    ResultW      = 32'h0;
    LlIssueValid = 1'b0;
    LlIssueRd    = 5'd0;
    LlValid      = 1'b0;
    LlRd         = 5'd0;
    LlData       = 32'h0;
  endtask

  // Issue an LLU op; the destination must not already be pending.
  task automatic issue_rd(input logic [4:0] rd);
    @(negedge clk);
    drive_idle();
    LlIssueValid = 1'b1;
    LlIssueRd    = rd;
    #1;
    checks++;
    if (PendingMask[rd] !== 1'b0) begin
      errors++;
      $display("FAIL issue_pending_rd%0d: mask=%h bit already set, required clear", rd, PendingMask);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    RegWriteW = 1'b1; RdW = 5'd8; ResultW = 32'h88;
    #1;
    checks++;
    if ({PendingMask, LlReady, StallReq} !== {32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: mask=%h ready=%b stall=%b required 0/1/0", PendingMask, LlReady, StallReq);
    end
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF} !== {1'b1, 5'd8, 32'h88}) begin
      errors++;
      $display("FAIL reset_passthru: got %b/%0d/%h required 1/8/00000088", RegWriteRF, RdRF, WriteDataRF);
    end
    RegWriteW = 1'b0;
    #1;
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF} !== {1'b0, 5'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset_idle_rf: got %b/%0d/%h required 0/0/0", RegWriteRF, RdRF, WriteDataRF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_drain();
    issue_rd(5'd5);
    @(negedge clk);
    drive_idle();
    LlValid = 1'b1; LlRd = 5'd5; LlData = 32'hDEADBEEF;
    #1;
    checks++;
    if (LlReady !== 1'b1) begin
      errors++;
      $display("FAIL t1_accept: ready=%b required 1", LlReady);
    end
    checks++;
    if ({RegWriteRF, PendingMask} !== {1'b0, 32'h20}) begin
      errors++;
      $display("FAIL t1_no_bypass: we=%b mask=%h required 0/00000020", RegWriteRF, PendingMask);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF, PendingMask} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h20}) begin
      errors++;
      $display("FAIL t1_drain: got %b/%0d/%h mask=%h required 1/5/deadbeef mask=00000020",
               RegWriteRF, RdRF, WriteDataRF, PendingMask);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF, PendingMask} !== {1'b0, 5'd0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL t1_after: got %b/%0d/%h mask=%h required 0/0/0 mask=0",
               RegWriteRF, RdRF, WriteDataRF, PendingMask);
    end
  endtask

  task automatic test_starvation();
    logic exp_stall;
    issue_rd(5'd6);
    issue_rd(5'd7);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive_idle();
      RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h11;
      if (c == 0) begin
        LlValid = 1'b1; LlRd = 5'd6; LlData = 32'h66;
      end else if (c == 1) begin
        LlValid = 1'b1; LlRd = 5'd7; LlData = 32'h77;
      end
      #1;
      exp_stall = (c == 5);
      checks++;
      if ({RegWriteRF, RdRF, WriteDataRF} !== {1'b1, 5'd3, 32'h11}) begin
        errors++;
        $display("FAIL t2_pipe_c%0d: got %b/%0d/%h required 1/3/00000011", c, RegWriteRF, RdRF, WriteDataRF);
      end
      checks++;
      if (LlReady !== (c < 2)) begin
        errors++;
        $display("FAIL t2_ready_c%0d: ready=%b required %b", c, LlReady, (c < 2));
      end
      checks++;
      if (StallReq !== exp_stall) begin
        errors++;
        $display("FAIL t2_stall_c%0d: stall=%b required %b", c, StallReq, exp_stall);
      end
    end
    checks++;
    if (PendingMask !== 32'h000000C0) begin
      errors++;
      $display("FAIL t2_mask: got %h required 000000c0", PendingMask);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF, StallReq} !== {1'b1, 5'd6, 32'h66, 1'b1}) begin
      errors++;
      $display("FAIL t2_drain6: got %b/%0d/%h stall=%b required 1/6/00000066 stall=1",
               RegWriteRF, RdRF, WriteDataRF, StallReq);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF, StallReq, LlReady} !== {1'b1, 5'd7, 32'h77, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL t2_drain7: got %b/%0d/%h stall=%b ready=%b required 1/7/00000077 stall=0 ready=1",
               RegWriteRF, RdRF, WriteDataRF, StallReq, LlReady);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({RegWriteRF, PendingMask, StallReq} !== {1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL t2_after: we=%b mask=%h stall=%b required 0/0/0", RegWriteRF, PendingMask, StallReq);
    end
  endtask

  task automatic test_set_wins();
    issue_rd(5'd9);
    @(negedge clk);
    drive_idle();
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h01;
    LlValid = 1'b1; LlRd = 5'd9; LlData = 32'h99;
    @(negedge clk);
    drive_idle();
    LlIssueValid = 1'b1; LlIssueRd = 5'd9;
    #1;
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF} !== {1'b1, 5'd9, 32'h99}) begin
      errors++;
      $display("FAIL t3_pop: got %b/%0d/%h required 1/9/00000099", RegWriteRF, RdRF, WriteDataRF);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({PendingMask, RegWriteRF} !== {32'h200, 1'b0}) begin
      errors++;
      $display("FAIL t3_set_wins: mask=%h we=%b required 00000200/0", PendingMask, RegWriteRF);
    end
    LlValid = 1'b1; LlRd = 5'd9; LlData = 32'h9A;
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF} !== {1'b1, 5'd9, 32'h9A}) begin
      errors++;
      $display("FAIL t3_cleanup: got %b/%0d/%h required 1/9/0000009a", RegWriteRF, RdRF, WriteDataRF);
    end
    @(negedge clk);
    #1;
    checks++;
    if (PendingMask !== 32'h0) begin
      errors++;
      $display("FAIL t3_mask_clear: got %h required 0", PendingMask);
    end
  endtask

  task automatic test_drop_rd0();
    issue_rd(5'd13);
    @(negedge clk);
    drive_idle();
    RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h22;
    LlValid = 1'b1; LlRd = 5'd13; LlData = 32'h13;
    @(negedge clk);
    LlRd = 5'd0; LlData = 32'h55;
    #1;
    checks++;
    if ({LlReady, RegWriteRF, RdRF, WriteDataRF} !== {1'b1, 1'b1, 5'd2, 32'h22}) begin
      errors++;
      $display("FAIL t4_accept0: ready=%b rf=%b/%0d/%h required 1 rf=1/2/00000022",
               LlReady, RegWriteRF, RdRF, WriteDataRF);
    end
    @(negedge clk);
    LlValid = 1'b0; LlRd = 5'd0; LlData = 32'h0;
    #1;
    checks++;
    if (LlReady !== 1'b1) begin
      errors++;
      $display("FAIL t4_count: ready=%b required 1 (one entry buffered)", LlReady);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF} !== {1'b1, 5'd13, 32'h13}) begin
      errors++;
      $display("FAIL t4_drain13: got %b/%0d/%h required 1/13/00000013", RegWriteRF, RdRF, WriteDataRF);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF, PendingMask} !== {1'b0, 5'd0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL t4_no_rd0: got %b/%0d/%h mask=%h required 0/0/0 mask=0",
               RegWriteRF, RdRF, WriteDataRF, PendingMask);
    end
  endtask

  task automatic test_slot_boundary();
    issue_rd(5'd12);
    @(negedge clk);
    drive_idle();
    RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h44;
    LlValid = 1'b1; LlRd = 5'd12; LlData = 32'hA5A5A5A5;
    @(negedge clk);
    drive_idle();
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFFFFFF;
    #1;
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF} !== {1'b1, 5'd12, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL t5_x0_free: got %b/%0d/%h required 1/12/a5a5a5a5", RegWriteRF, RdRF, WriteDataRF);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({RegWriteRF, PendingMask} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL t5_after: we=%b mask=%h required 0/0", RegWriteRF, PendingMask);
    end
  endtask

  task automatic test_reset_mid();
    issue_rd(5'd5);
    issue_rd(5'd6);
    @(negedge clk);
    drive_idle();
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h11;
    LlValid = 1'b1; LlRd = 5'd5; LlData = 32'h55;
    @(negedge clk);
    LlRd = 5'd6; LlData = 32'h66;
    @(negedge clk);
    LlValid = 1'b0; LlRd = 5'd0; LlData = 32'h0;
    #1;
    checks++;
    if ({PendingMask, LlReady} !== {32'h60, 1'b0}) begin
      errors++;
      $display("FAIL t6_pre: mask=%h ready=%b required 00000060/0", PendingMask, LlReady);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({PendingMask, LlReady, StallReq} !== {32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL t6_async: mask=%h ready=%b stall=%b required 0/1/0", PendingMask, LlReady, StallReq);
    end
    checks++;
    if ({RegWriteRF, RdRF, WriteDataRF} !== {1'b1, 5'd3, 32'h11}) begin
      errors++;
      $display("FAIL t6_passthru: got %b/%0d/%h required 1/3/00000011", RegWriteRF, RdRF, WriteDataRF);
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({RegWriteRF, RdRF, WriteDataRF, PendingMask} !== {1'b0, 5'd0, 32'h0, 32'h0}) begin
        errors++;
        $display("FAIL t6_stale_c%0d: got %b/%0d/%h mask=%h required 0/0/0 mask=0",
                 c, RegWriteRF, RdRF, WriteDataRF, PendingMask);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive_idle();
    test_reset();
    test_idle_drain();
    test_starvation();
    test_set_wins();
    test_drop_rd0();
    test_slot_boundary();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback result (the writeback-stage mux output);
  - results from long-latency units (LLUs), such as an iterative divider or multi-cycle memory.
- Buffers LLU results in a small FIFO and drains them into idle writeback slots.
- Keeps a pending-destination scoreboard that the hazard unit uses for RAW/WAW stalls.
- Requests a pipeline bubble when buffered results are starved of write slots.

Parameters:
- XLEN, 32, datapath width.
- DEPTH, 2, LLU result FIFO entries; must be a power of 2, at least 2.
- STARVE_LIMIT, 4, consecutive blocked cycles with FIFO non-empty before StallReq asserts.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RegWriteW  in  1  pipeline writeback enable.
- RdW  in  5  pipeline destination register.
- ResultW  in  XLEN  pipeline writeback data.
- LlIssueValid  in  1  an LLU op is issued this cycle.
- LlIssueRd  in  5  destination of the issued LLU op.
- LlValid  in  1  LLU offers a result.
- LlRd  in  5  destination of the offered result.
- LlData  in  XLEN  offered result data.
- LlReady  out  1  arbiter accepts the LLU result this cycle.
- RegWriteRF  out  1  register-file write enable.
- RdRF  out  5  register-file write address.
- WriteDataRF  out  XLEN  register-file write data.
- PendingMask  out  32  bit i set means an LLU write to xi is outstanding.
- StallReq  out  1  request to freeze the front end and bubble writeback.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, PendingMask = 0, starve counter = 0, StallReq = 0, LlReady = 1.
  - RF outputs follow the pipeline-pass-through rule below.
- Slot rule: the pipeline slot is busy when RegWriteW = 1 and RdW != 0; otherwise it is free.
- Pipeline priority:
  - If the slot is busy: RegWriteRF = 1, RdRF = RdW, WriteDataRF = ResultW. Combinational, zero latency.
- Drain:
  - If the slot is free and the FIFO is non-empty: RegWriteRF = 1 with RdRF/WriteDataRF taken from the FIFO head. The entry pops at the clock edge.
  - If the slot is free and the FIFO is empty: RegWriteRF = 0, RdRF = 0, WriteDataRF = 0.
- LLU handshake:
  - LlReady = !full, registered-state only; no combinational path from LlValid.
  - Transfer occurs on LlValid & LlReady.
  - An accepted result with LlRd = 0 is consumed and dropped, never enqueued.
  - LlValid/LlRd/LlData must stay stable while LlValid is high and LlReady is low.
- No bypass: an accepted result reaches the RF no earlier than the next cycle.
- Push and pop in the same cycle are allowed whenever not full. Count is unchanged; pointers wrap modulo DEPTH.
- Full: LlReady = 0. A pop in that cycle does not make LlReady high until the following cycle.
- Scoreboard:
  - LlIssueValid with LlIssueRd != 0 sets that bit on the clock edge.
  - A FIFO pop clears bit RdRF on the clock edge.
  - Set and clear of the same bit in the same cycle: set wins.
  - Bit 0 is always 0.
  - LlIssueValid to an already-pending rd is illegal; the hazard unit guarantees it never happens, and the bench flags it.
- Starvation:
  - The counter increments when the FIFO is non-empty and the slot is busy, saturating at STARVE_LIMIT.
  - It clears on any pop or when the FIFO is empty.
  - StallReq = (counter == STARVE_LIMIT), registered.
  - StallReq drops the cycle after the pop that the resulting bubble enables.
- Ordering: results write in FIFO acceptance order. WAW against the pipeline is prevented externally via PendingMask.
- Reset mid-operation: buffered results and pending bits are discarded. The LLU is reset by the same rst_n.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN, REG_ADDR_W = 5, NUM_REGS = 32;
  - the packed LLU result struct {rd[4:0], data[XLEN-1:0]}.
- One sub-module: llu_result_fifo, a synchronous FIFO.
  - Parameterised DEPTH and width.
  - Ports: push, pop, full, empty, head data; same clk/rst_n.
- The scoreboard and starve counter stay in the top.

Test Plan:
1. Idle pipeline (RegWriteW = 0): issue x5, then LLU offers rd 5 with data 0xDEADBEEF. Required: accepted that cycle; next cycle RegWriteRF = 1, RdRF = 5, WriteDataRF = 0xDEADBEEF; PendingMask bit 5 clears after that edge.
2. Pipeline writes x3 = 0x11 every cycle while the LLU delivers 2 results (x6, x7). Required: RF always shows x3; LlReady = 0 after 2 accepts; StallReq = 1 after 4 blocked cycles. With RegWriteW = 0 for two cycles: x6 then x7 written in order, StallReq returns to 0.
3. Simultaneous events: FIFO holds x9, slot free, LlIssueValid with rd 9 in the same cycle as the pop of x9. Required: PendingMask bit 9 remains 1.
4. LLU result with LlRd = 0 and data 0x55: accepted, never appears on RF outputs, FIFO count unchanged.
5. Slot-rule boundary: RegWriteW = 1 with RdW = 0 while FIFO holds x12 = 0xA5A5A5A5. Required: same-cycle drain writes x12.
6. Reset mid-operation: assert rst_n low with 2 entries buffered and PendingMask = 0x00000060. Required: immediately PendingMask = 0, LlReady = 1, StallReq = 0, no stale write after release.
